// File: rtl/reg_file_mp_pkg.sv
// rtl/reg_file_mp_pkg.sv - default sizes, address type and popcount helper for reg_file_mp
package reg_file_mp_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;
  localparam int NUM_RD_DEF = 2;
  localparam int NUM_WR_DEF = 2;

  // popcount operates on a fixed-width vector; callers zero-pad narrower busy vectors
  localparam int POP_MAX_W  = 256;

  typedef logic [ADDR_W_DEF-1:0] reg_addr_t;

  function automatic logic [15:0] popcount(input logic [POP_MAX_W-1:0] vec);
    logic [15:0] cnt;
    cnt = '0;
    for (int i = 0; i < POP_MAX_W; i++) begin
      cnt = cnt + 16'(vec[i]);
    end
    return cnt;
  endfunction

endpackage

// File: rtl/reg_file_mp_wsel.sv
// rtl/reg_file_mp_wsel.sv - write-port priority resolver; highest-index enabled port matching tgt_addr wins
module reg_file_mp_wsel #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NUM_WR = 2
) (
  input  logic [NUM_WR-1:0]        wr_en,
  input  logic [NUM_WR*ADDR_W-1:0] wr_addr,
  input  logic [NUM_WR*DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0]        tgt_addr,
  output logic                     hit,
  output logic [DATA_W-1:0]        data
);

  always_comb begin
    hit  = 1'b0;
    data = '0;
    for (int j = 0; j < NUM_WR; j++) begin
      if (wr_en[j] && (wr_addr[j*ADDR_W +: ADDR_W] == tgt_addr)) begin
        hit  = 1'b1;
        data = wr_data[j*DATA_W +: DATA_W];
      end
    end
  end

endmodule

// File: rtl/reg_file_mp.sv
// rtl/reg_file_mp.sv - multi-port register file with busy-bit scoreboard
// Optional same-cycle write-to-read bypass: REG_FILE_MP_BYPASS_EN
module reg_file_mp
  import reg_file_mp_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int NUM_RD   = NUM_RD_DEF,
  parameter int NUM_WR   = NUM_WR_DEF,
  parameter int ZERO_REG = 1
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr_i,
  output logic [NUM_RD*DATA_W-1:0] rd_data_o,
  output logic [NUM_RD-1:0]        rd_busy_o,
  input  logic [NUM_WR-1:0]        wr_en_i,
  input  logic [NUM_WR*ADDR_W-1:0] wr_addr_i,
  input  logic [NUM_WR*DATA_W-1:0] wr_data_i,
  input  logic                     sb_set_i,
  input  logic [ADDR_W-1:0]        sb_addr_i,
  output logic [(2**ADDR_W)-1:0]   busy_vec_o,
  output logic [ADDR_W:0]          busy_cnt_o
);

  localparam int DEPTH = 2**ADDR_W;

  logic [DATA_W-1:0]             regs [DEPTH];
  logic [DEPTH-1:0]              busy_q;
  logic [DEPTH-1:0]              busy_next;
  logic [POP_MAX_W-1:0]          busy_pad;
  logic [DEPTH-1:0]              wr_hit;
  logic [DEPTH-1:0][DATA_W-1:0]  wr_val;
  logic                          sb_set_ok;

  for (genvar i = 0; i < DEPTH; i++) begin : g_reg
    logic hit_raw;
    reg_file_mp_wsel #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_WR(NUM_WR)) u_wsel (
      .wr_en    (wr_en_i),
      .wr_addr  (wr_addr_i),
      .wr_data  (wr_data_i),
      .tgt_addr (ADDR_W'(i)),
      .hit      (hit_raw),
      .data     (wr_val[i])
    );
    // hardwired zero register never accepts a write
    assign wr_hit[i] = (ZERO_REG != 0 && i == 0) ? 1'b0 : hit_raw;
  end

  assign sb_set_ok = sb_set_i && !(ZERO_REG != 0 && sb_addr_i == '0);

  // clears first, then set, so a new producer overrides a retiring one
  always_comb begin
    busy_next = busy_q & ~wr_hit;
    if (sb_set_ok) begin
      busy_next[sb_addr_i] = 1'b1;
    end
    busy_pad = '0;
    busy_pad[DEPTH-1:0] = busy_next;
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs[i] <= '0;
      end
      busy_q     <= '0;
      busy_cnt_o <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (wr_hit[i]) begin
          regs[i] <= wr_val[i];
        end
      end
      busy_q     <= busy_next;
      busy_cnt_o <= (ADDR_W+1)'(popcount(busy_pad));
    end
  end

  assign busy_vec_o = busy_q;

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic              busy;
    assign addr = rd_addr_i[k*ADDR_W +: ADDR_W];
`ifdef REG_FILE_MP_BYPASS_EN
    logic              byp_hit;
    logic [DATA_W-1:0] byp_data;
    reg_file_mp_wsel #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_WR(NUM_WR)) u_byp (
      .wr_en    (wr_en_i),
      .wr_addr  (wr_addr_i),
      .wr_data  (wr_data_i),
      .tgt_addr (addr),
      .hit      (byp_hit),
      .data     (byp_data)
    );
`endif
    always_comb begin
      data = regs[addr];
      busy = busy_q[addr];
`ifdef REG_FILE_MP_BYPASS_EN
      if (byp_hit) begin
        data = byp_data;
        busy = sb_set_i && (sb_addr_i == addr);
      end
`endif
      if (ZERO_REG != 0 && addr == '0) begin
        data = '0;
        busy = 1'b0;
      end
    end
    assign rd_data_o[k*DATA_W +: DATA_W] = data;
    assign rd_busy_o[k] = busy;
  end

endmodule

// File: tb/tb_reg_file_mp.sv
// tb/tb_reg_file_mp.sv - directed self-checking bench for reg_file_mp
module tb_reg_file_mp;
  import reg_file_mp_pkg::*;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [9:0]  rd_addr_i;
  logic [63:0] rd_data_o;
  logic [1:0]  rd_busy_o;
  logic [1:0]  wr_en_i;
  logic [9:0]  wr_addr_i;
  logic [63:0] wr_data_i;
  logic        sb_set_i;
  logic [4:0]  sb_addr_i;
  logic [31:0] busy_vec_o;
  logic [5:0]  busy_cnt_o;

  int tests = 0;
  int fails = 0;

  reg_file_mp dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .rd_addr_i  (rd_addr_i),
    .rd_data_o  (rd_data_o),
    .rd_busy_o  (rd_busy_o),
    .wr_en_i    (wr_en_i),
    .wr_addr_i  (wr_addr_i),
    .wr_data_i  (wr_data_i),
    .sb_set_i   (sb_set_i),
    .sb_addr_i  (sb_addr_i),
    .busy_vec_o (busy_vec_o),
    .busy_cnt_o (busy_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle();
    wr_en_i  = '0;
    sb_set_i = 1'b0;
  endtask

`ifdef REG_FILE_MP_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  initial begin
    reg_addr_t a0, a1;
    rst_i     = 1'b0;
    rd_addr_i = '0;
    wr_en_i   = '0;
    wr_addr_i = '0;
    wr_data_i = '0;
    sb_set_i  = 1'b0;
    sb_addr_i = '0;
    #2;
    chk("reset_busy_vec", 64'(busy_vec_o), 64'h0);
    chk("reset_busy_cnt", 64'(busy_cnt_o), 64'h0);
    chk("reset_rd_data", rd_data_o, 64'h0);
    #1;
    rst_i = 1'b1;

    // r5 <= DEADBEEF via port0, read r5 in the same cycle
    a0 = 5'd5;
    rd_addr_i = {5'd0, a0};
    wr_en_i   = 2'b01;
    wr_addr_i = {5'd0, 5'd5};
    wr_data_i = {32'h0, 32'hDEADBEEF};
    #1;
    chk("same_cycle_r5", 64'(rd_data_o[31:0]), BYP ? 64'hDEADBEEF : 64'h0);
    step();
    idle();
    #1;
    chk("next_cycle_r5", 64'(rd_data_o[31:0]), 64'hDEADBEEF);

    // both ports write r7; port1 must win
    wr_en_i   = 2'b11;
    wr_addr_i = {5'd7, 5'd7};
    wr_data_i = {32'h22, 32'h11};
    step();
    idle();
    a1 = 5'd7;
    rd_addr_i = {a1, 5'd5};
    #1;
    chk("conflict_r7", 64'(rd_data_o[63:32]), 64'h22);
    chk("r5_unaffected", 64'(rd_data_o[31:0]), 64'hDEADBEEF);

    // zero register ignores write and scoreboard set
    wr_en_i   = 2'b01;
    wr_addr_i = {5'd0, 5'd0};
    wr_data_i = {32'h0, 32'h55};
    sb_set_i  = 1'b1;
    sb_addr_i = 5'd0;
    rd_addr_i = {5'd0, 5'd0};
    #1;
    chk("r0_same_cycle", 64'(rd_data_o[31:0]), 64'h0);
    step();
    idle();
    #1;
    chk("r0_data", 64'(rd_data_o[31:0]), 64'h0);
    chk("r0_busy_vec", 64'(busy_vec_o[0]), 64'h0);
    chk("r0_busy_cnt", 64'(busy_cnt_o), 64'h0);

    // scoreboard: set r3
    sb_set_i  = 1'b1;
    sb_addr_i = 5'd3;
    step();
    idle();
    rd_addr_i = {5'd3, 5'd0};
    #1;
    chk("sb_set_r3_vec", 64'(busy_vec_o), 64'h8);
    chk("sb_set_r3_cnt", 64'(busy_cnt_o), 64'd1);
    chk("sb_set_r3_rdbusy", 64'(rd_busy_o[1]), 64'h1);

    // write r3 and re-set r3 together: stays busy
    wr_en_i   = 2'b01;
    wr_addr_i = {5'd0, 5'd3};
    wr_data_i = {32'h0, 32'h33};
    sb_set_i  = 1'b1;
    sb_addr_i = 5'd3;
    step();
    idle();
    #1;
    chk("set_clr_r3_vec", 64'(busy_vec_o), 64'h8);
    chk("set_clr_r3_cnt", 64'(busy_cnt_o), 64'd1);

    // write r3 alone: retires
    wr_en_i   = 2'b10;
    wr_addr_i = {5'd3, 5'd0};
    wr_data_i = {32'h44, 32'h0};
    step();
    idle();
    #1;
    chk("clr_r3_vec", 64'(busy_vec_o), 64'h0);
    chk("clr_r3_cnt", 64'(busy_cnt_o), 64'd0);
    chk("clr_r3_data", 64'(rd_data_o[63:32]), 64'h44);
    chk("clr_r3_rdbusy", 64'(rd_busy_o[1]), 64'h0);

    // fill r1..r31
    for (int a = 1; a < 32; a++) begin
      sb_set_i  = 1'b1;
      sb_addr_i = 5'(a);
      step();
    end
    idle();
    #1;
    chk("fill_cnt", 64'(busy_cnt_o), 64'd31);
    chk("fill_vec", 64'(busy_vec_o), 64'hFFFF_FFFE);

    // clearing write to r9 on port1 with same-cycle read of r9
    wr_en_i   = 2'b10;
    wr_addr_i = {5'd9, 5'd0};
    wr_data_i = {32'h99, 32'h0};
    rd_addr_i = {5'd10, 5'd9};
    #1;
    chk("byp_r9_busy", 64'(rd_busy_o[0]), BYP ? 64'h0 : 64'h1);
    chk("byp_r9_data", 64'(rd_data_o[31:0]), BYP ? 64'h99 : 64'h0);
    step();
    idle();
    #1;
    chk("after_r9_cnt", 64'(busy_cnt_o), 64'd30);
    chk("after_r9_vec", 64'(busy_vec_o), 64'hFFFF_FDFE);

    // write r10 with same-cycle reissue of r10: busy reported either way
    wr_en_i   = 2'b01;
    wr_addr_i = {5'd0, 5'd10};
    wr_data_i = {32'h0, 32'hA0};
    sb_set_i  = 1'b1;
    sb_addr_i = 5'd10;
    #1;
    chk("byp_r10_busy", 64'(rd_busy_o[1]), 64'h1);
    chk("byp_r10_data", 64'(rd_data_o[63:32]), BYP ? 64'hA0 : 64'h0);
    step();
    idle();
    #1;
    chk("r10_cnt", 64'(busy_cnt_o), 64'd30);

    // asynchronous reset mid-cycle
    rd_addr_i = {5'd7, 5'd5};
    #1;
    chk("pre_rst_r5", 64'(rd_data_o[31:0]), 64'hDEADBEEF);
    rst_i = 1'b0;
    #1;
    chk("async_rst_data", rd_data_o, 64'h0);
    chk("async_rst_vec", 64'(busy_vec_o), 64'h0);
    chk("async_rst_cnt", 64'(busy_cnt_o), 64'h0);
    step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/reg_file_mp.md
Name: reg_file_mp

Overview:
- Parametrised multi-port register file with an integrated busy-bit scoreboard; next-generation register file for the pipelined CPU datapath.
- Provides NUM_RD combinational read ports and NUM_WR clocked write-back ports.
- Per-register busy bits let decode detect RAW hazards on in-flight results; register 0 is optionally hardwired to zero.

Parameters:
- DATA_W, 32, register width in bits
- ADDR_W, 5, address width; DEPTH = 2**ADDR_W registers
- NUM_RD, 2, number of read ports
- NUM_WR, 2, number of write ports
- ZERO_REG, 1, 1 = register 0 reads 0, ignores writes, never busy

Ports:
- clk_i  in  1  clock, rising edge
- rst_i  in  1  asynchronous active-low reset
- rd_addr_i  in  NUM_RD*ADDR_W  read addresses, port k at bits [k*ADDR_W +: ADDR_W]
- rd_data_o  out  NUM_RD*DATA_W  read data, packed the same way
- rd_busy_o  out  NUM_RD  busy bit of each read address
- wr_en_i  in  NUM_WR  write enable per port
- wr_addr_i  in  NUM_WR*ADDR_W  write addresses
- wr_data_i  in  NUM_WR*DATA_W  write data
- sb_set_i  in  1  mark sb_addr_i busy (instruction issued with destination)
- sb_addr_i  in  ADDR_W  destination being issued
- busy_vec_o  out  DEPTH  all busy bits, registered
- busy_cnt_o  out  ADDR_W+1  population count of busy_vec_o, registered

Behaviour:
- Reset: while rst_i=0, asynchronously clear all registers, busy_vec_o and busy_cnt_o to 0. rd_data_o and rd_busy_o then read 0. Deassertion is sampled at clk_i.
- Reads: combinational, zero latency from rd_addr_i.
- Writes:
  - Take effect at the rising edge of clk_i when wr_en_i[j]=1.
  - If several enabled ports target the same address in the same cycle, the highest-index port wins.
  - If a port is not enabled, its register holds its value.
- ZERO_REG=1:
  - Writes to address 0 are dropped.
  - sb_set_i with sb_addr_i=0 is ignored.
  - Reads of address 0 return 0 and busy 0 regardless of bypass.
- Scoreboard, at each edge, in this order:
  - (1) Every enabled write clears the busy bit of its address.
  - (2) sb_set_i sets the busy bit of sb_addr_i.
  - Set and clear of the same address in the same cycle leaves it busy, because the new producer wins.
  - Setting an already-busy bit keeps it at 1; there is no counting per register.
- busy_cnt_o equals the popcount of the next busy vector, registered in the same edge; range 0..DEPTH.
- A write to a non-busy register is legal; it updates data and the busy bit stays 0.
- An active reset during a write or set discards that operation; the reset value wins.
- Address ranges are full width; no out-of-range case exists.

Optional Feature:
- Macro: REG_FILE_MP_BYPASS_EN.
- Defined: a read port whose address matches an enabled same-cycle write returns that write data (highest matching port wins) and reports rd_busy_o=0, unless sb_set_i targets the same address in that cycle (then busy=1, data still bypassed).
- Undefined: reads return the pre-edge register contents and busy bits; new values become visible the cycle after the write.

Decomposition:
- Package reg_file_mp_pkg: default DATA_W/ADDR_W/NUM_RD/NUM_WR constants, a reg-address typedef, and a function popcount for busy_cnt.
- One natural sub-module: reg_file_mp_wsel, a combinational write-port priority resolver. It takes the wr_en/addr/data vectors and a target address and returns hit and data. It is shared by the write path (per register) and by the bypass path (per read port).

Test Plan:
- Reset: hold rst_i=0 mid-run after writes -> all rd_data_o=0, busy_vec_o=0, busy_cnt_o=0 immediately, without waiting for a clock edge.
- Write/read: port0 writes 0xDEADBEEF to r5; read r5 next cycle -> 0xDEADBEEF. With a same-cycle read, the result is 0xDEADBEEF if bypass is enabled, old value 0 otherwise.
- Port conflict: wr0 r7=0x11 and wr1 r7=0x22 in one cycle -> r7=0x22.
- Zero register: write 0x55 to r0 and sb_set r0 -> r0 reads 0, busy_vec_o[0]=0, busy_cnt_o unchanged.
- Scoreboard:
  - sb_set r3 -> busy_vec_o[3]=1, busy_cnt_o=1.
  - Next cycle wr r3 together with sb_set r3 -> still busy, count 1.
  - Following cycle wr r3 alone -> busy 0, count 0.
- Fill: sb_set r1..r31 over 31 cycles -> busy_cnt_o=31; bypass read of r9 during its clearing write -> rd_busy_o=0.
